// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift-add-3) with start/busy/done handshake
// driving six active-low 7-segment displays. Optional: BCD_LEADING_ZERO_BLANK_EN.
module bcd_seq_ctrl #(
    parameter int BIT_SIZE  = 10,
    parameter int SEGMENTOS = 7,
    parameter int DIGITS    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIT_SIZE-1:0]   binary_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [0:SEGMENTOS-1]  D_unidades,
    output logic [0:SEGMENTOS-1]  D_decenas,
    output logic [0:SEGMENTOS-1]  D_centenas,
    output logic [0:SEGMENTOS-1]  D_millares,
    output logic [0:SEGMENTOS-1]  D_decenas_millares,
    output logic [0:SEGMENTOS-1]  D_centenas_millares
);
    localparam int CW = $clog2(BIT_SIZE + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, ADJUST, SHIFT} state_t;

    state_t                 state_q;
    logic [BIT_SIZE-1:0]    bin_q;
    logic [BW-1:0]          bcd_q;
    logic [BW-1:0]          bcd_out_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q;
    logic                   done_q;

    logic [BW-1:0]          adj_d;
    logic [BW+BIT_SIZE-1:0] shift_d;

    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    assign shift_d = {bcd_q, bin_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            bcd_out_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bin_q   <= binary_in;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(BIT_SIZE);
                        busy_q  <= 1'b1;
                        state_q <= ADJUST;
                    end
                end
                ADJUST: begin
                    bcd_q   <= adj_d;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    bcd_q <= shift_d[BW+BIT_SIZE-1 -: BW];
                    bin_q <= shift_d[BIT_SIZE-1:0];
                    cnt_q <= cnt_q - 1'b1;
                    // Last shift: commit the freshly shifted value, not the stale bcd_q
                    if (cnt_q == CW'(1)) begin
                        bcd_out_q <= shift_d[BW+BIT_SIZE-1 -: BW];
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        state_q <= ADJUST;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_out_q;

    // Bit 6 is segment a, so the packed value lines up with the [0:6] port ordering.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [6:0] segs [DIGITS];

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic lz;
    always_comb begin
        lz = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            segs[i] = seg7(bcd_out_q[4*i +: 4]);
            lz      = lz && (bcd_out_q[4*i +: 4] == 4'd0);
            if (lz && i != 0) segs[i] = 7'b1111111;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < DIGITS; i++) segs[i] = seg7(bcd_out_q[4*i +: 4]);
    end
`endif

    assign D_unidades          = segs[0];
    assign D_decenas           = segs[1];
    assign D_centenas          = segs[2];
    assign D_millares          = segs[3];
    assign D_decenas_millares  = segs[4];
    assign D_centenas_millares = segs[5];
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: handshake timing, results, display codes,
// ignored/back-to-back starts and asynchronous reset abort.
module tb_bcd_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  binary_in;
    logic        busy, done;
    logic [23:0] bcd_out;
    logic [0:6]  d_u, d_t, d_h, d_th, d_tt, d_ht;

    int vecs = 0;
    int errs = 0;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S9 = 7'b0000100;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b0000001;
`endif

    bcd_seq_ctrl #(.BIT_SIZE(10), .SEGMENTOS(7), .DIGITS(6)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .binary_in           (binary_in),
        .busy                (busy),
        .done                (done),
        .bcd_out             (bcd_out),
        .D_unidades          (d_u),
        .D_decenas           (d_t),
        .D_centenas          (d_h),
        .D_millares          (d_th),
        .D_decenas_millares  (d_tt),
        .D_centenas_millares (d_ht)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input string tag, input logic [6:0] u, input logic [6:0] t,
                        input logic [6:0] h, input logic [6:0] th,
                        input logic [6:0] tt, input logic [6:0] ht);
        chk({tag, "_units"},  32'(d_u),  32'(u));
        chk({tag, "_tens"},   32'(d_t),  32'(t));
        chk({tag, "_hund"},   32'(d_h),  32'(h));
        chk({tag, "_thou"},   32'(d_th), 32'(th));
        chk({tag, "_tthou"},  32'(d_tt), 32'(tt));
        chk({tag, "_hthou"},  32'(d_ht), 32'(ht));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion: accept edge, 19 busy cycles, done cycle, idle cycle.
    // inj >= 1 pulses start with binary_in=5 for one edge while busy.
    task automatic conv(input string tag, input logic [9:0] v, input logic [23:0] exp,
                        input logic [23:0] prev, input int inj);
        start = 1'b1;
        binary_in = v;
        tick();
        start = 1'b0;
        binary_in = ~v;
        chk({tag, "_busy0"}, 32'({busy, done}), 32'(2'b10));
        for (int j = 1; j < 20; j++) begin
            if (j == inj) begin
                start = 1'b1;
                binary_in = 10'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            chk({tag, "_busy"}, 32'({busy, done}), 32'(2'b10));
            if (j == 10) chk({tag, "_hold"}, 32'(bcd_out), 32'(prev));
        end
        start = 1'b0;
        tick();
        chk({tag, "_done"}, 32'({busy, done}), 32'(2'b01));
        chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp));
        tick();
        chk({tag, "_idle"}, 32'({busy, done}), 32'(2'b00));
        chk({tag, "_keep"}, 32'(bcd_out), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        binary_in = '0;
        repeat (2) tick();
        chk("rst_busy_done", 32'({busy, done}), 32'(2'b00));
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        disp("rst", S0, LZ, LZ, LZ, LZ, LZ);
        rst_n = 1'b1;
        tick();

        conv("zero", 10'd0, 24'h000000, 24'h000000, -1);
        disp("zero", S0, LZ, LZ, LZ, LZ, LZ);

        conv("c1023", 10'd1023, 24'h001023, 24'h000000, -1);
        disp("c1023", S3, S2, S0, S1, LZ, LZ);

        // Start while busy is dropped; displays keep 1023 until commit
        conv("c999", 10'd999, 24'h000999, 24'h001023, 5);
        disp("c999", S9, S9, S9, LZ, LZ, LZ);
        repeat (22) begin
            tick();
            chk("c999_noq", 32'({busy, done}), 32'(2'b00));
        end

        // Asynchronous abort mid-conversion
        start = 1'b1;
        binary_in = 10'd512;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy_done", 32'({busy, done}), 32'(2'b00));
        chk("abort_bcd", 32'(bcd_out), 32'h0);
        disp("abort", S0, LZ, LZ, LZ, LZ, LZ);
        tick();
        rst_n = 1'b1;
        repeat (25) begin
            tick();
            chk("abort_quiet", 32'({busy, done}), 32'(2'b00));
        end

        // Back-to-back: start held through the done cycle
        start = 1'b1;
        binary_in = 10'd37;
        tick();
        binary_in = 10'd400;
        for (int j = 1; j < 20; j++) begin
            tick();
            chk("b2b_busy", 32'({busy, done}), 32'(2'b10));
        end
        tick();
        chk("b2b_done1", 32'({busy, done}), 32'(2'b01));
        chk("b2b_bcd1", 32'(bcd_out), 32'h000037);
        tick();
        start = 1'b0;
        chk("b2b_restart", 32'({busy, done}), 32'(2'b10));
        for (int j = 1; j < 20; j++) begin
            tick();
            chk("b2b_busy2", 32'({busy, done}), 32'(2'b10));
        end
        tick();
        chk("b2b_done2", 32'({busy, done}), 32'(2'b01));
        chk("b2b_bcd2", 32'(bcd_out), 32'h000400);
        tick();

        conv("c5", 10'd5, 24'h000005, 24'h000400, -1);
        disp("c5", S5, LZ, LZ, LZ, LZ, LZ);
        conv("c0", 10'd0, 24'h000000, 24'h000005, -1);
        disp("c0", S0, LZ, LZ, LZ, LZ, LZ);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
